xnor_frame_compare: RTL and testbench

Bit-serial frame comparator sitting directly downstream of the `xnorg` gate. Two serial bit streams are presented one bit pair per accepted cycle. Each pair is judged by XNOR equivalence (match when `a_bit` equals `b_bit`). Over a frame of FRAME_LEN bits the block accumulates a mismatch count and the index of the first mismatch, then reports a registered equal/not-equal verdict with a one-cycle done pulse.

---
 rtl/xnor_frame_compare_if.sv | 26 ++
 rtl/xnor_frame_compare.sv | 75 +++++++
 tb/tb_xnor_frame_compare.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/xnor_frame_compare_if.sv
// xnor_frame_compare_if: serial pair stream in, frame verdict out.
//   master drives start/bit_valid/a_bit/b_bit and observes the results;
//   slave (the comparator) drives busy/done/equal/mismatch_cnt/first_mismatch.
interface xnor_frame_compare_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             equal;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_mismatch;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, equal, mismatch_cnt, first_mismatch
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, equal, mismatch_cnt, first_mismatch
    );
endinterface

// File: rtl/xnor_frame_compare.sv
// xnor_frame_compare: counts XNOR mismatches over a FRAME_LEN-bit serial frame.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of xnor_frame_compare_if (start, bit pairs in; busy, done, verdict out)
module xnor_frame_compare #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input logic                 clk,
    input logic                 rst,
    xnor_frame_compare_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // first_mismatch == FRAME_LEN doubles as the "no mismatch seen yet" marker
    localparam logic [CNT_W-1:0] NONE = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             equal_q, equal_d;
    logic             match;

    assign match = ~(bus.a_bit ^ bus.b_bit);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        equal_d = equal_q;
        if (state_q != RUN && bus.start) begin
            state_d = RUN;
            idx_d   = '0;
            cnt_d   = '0;
            first_d = NONE;
            equal_d = 1'b0;
        end else if (state_q == RUN && bus.bit_valid) begin
            if (!match) begin
                cnt_d   = cnt_q + CNT_W'(1);
                first_d = (first_q == NONE) ? idx_q : first_q;
            end
            idx_d = idx_q + CNT_W'(1);
            if (idx_q == LAST) begin
                state_d = DONE;
                equal_d = (cnt_d == '0);
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            equal_q <= equal_d;
        end
    end

    assign bus.busy           = (state_q == RUN);
    assign bus.done           = (state_q == DONE);
    assign bus.equal          = equal_q;
    assign bus.mismatch_cnt   = cnt_q;
    assign bus.first_mismatch = first_q;
endmodule

// File: tb/tb_xnor_frame_compare.sv
// tb_xnor_frame_compare: table-driven and randomized frame checks for xnor_frame_compare.
module tb_xnor_frame_compare;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    xnor_frame_compare_if #(.CNT_W(4)) bus();

    xnor_frame_compare #(.FRAME_LEN(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Frame bits are written MSB-first: bit index i lives at position 7-i.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         stall_after;
        int         stall_n;
        bit         hold;
        int         idle_n;
        bit         exp_eq;
        int         exp_cnt;
        int         exp_first;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_equal"}, 32'(bus.equal), 0);
        chk({tag, "_cnt"}, 32'(bus.mismatch_cnt), 0);
        chk({tag, "_first"}, 32'(bus.first_mismatch), 0);
    endtask

    function automatic int model_cnt(input logic [7:0] a, input logic [7:0] b);
        int c = 0;
        for (int i = 0; i < 8; i++) if (a[7-i] != b[7-i]) c++;
        return c;
    endfunction

    function automatic int model_first(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++) if (a[7-i] != b[7-i]) return i;
        return 8;
    endfunction

    // Issues start, feeds 8 pairs (optional stall), checks done exactly one cycle after the last pair.
    // Returns with the DUT in its DONE cycle.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input int stall_after,
                             input int stall_n, input bit hold, input bit exp_eq,
                             input int exp_cnt, input int exp_first);
        int live = 0;
        bus.start     = 1'b1;
        bus.bit_valid = 1'b0;
        tick();
        bus.start = hold;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_done", 32'(bus.done), 0);
        chk("start_equal", 32'(bus.equal), 0);
        chk("start_cnt", 32'(bus.mismatch_cnt), 0);
        chk("start_first", 32'(bus.first_mismatch), 8);
        for (int i = 0; i < 8; i++) begin
            bus.bit_valid = 1'b1;
            bus.a_bit     = a[7-i];
            bus.b_bit     = b[7-i];
            if (a[7-i] != b[7-i]) live++;
            tick();
            if (i < 7) begin
                chk("run_busy", 32'(bus.busy), 1);
                chk("run_done", 32'(bus.done), 0);
                chk("run_cnt", 32'(bus.mismatch_cnt), 32'(live));
            end
            if (i == stall_after) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.bit_valid = 1'b0;
                    bus.a_bit     = 1'($urandom);
                    bus.b_bit     = 1'($urandom);
                    tick();
                    chk("stall_busy", 32'(bus.busy), 1);
                    chk("stall_done", 32'(bus.done), 0);
                    chk("stall_cnt", 32'(bus.mismatch_cnt), 32'(live));
                end
            end
        end
        bus.bit_valid = 1'b0;
        chk("fin_done", 32'(bus.done), 1);
        chk("fin_busy", 32'(bus.busy), 0);
        chk("fin_equal", 32'(bus.equal), 32'(exp_eq));
        chk("fin_cnt", 32'(bus.mismatch_cnt), 32'(exp_cnt));
        chk("fin_first", 32'(bus.first_mismatch), 32'(exp_first));
    endtask

    // Idle after a frame: bit_valid noise must be ignored and results must hold.
    task automatic idle_hold(input int n, input bit exp_eq, input int exp_cnt, input int exp_first);
        bus.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.bit_valid = 1'($urandom);
            bus.a_bit     = 1'($urandom);
            bus.b_bit     = 1'($urandom);
            tick();
            chk("idle_done", 32'(bus.done), 0);
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_equal", 32'(bus.equal), 32'(exp_eq));
            chk("idle_cnt", 32'(bus.mismatch_cnt), 32'(exp_cnt));
            chk("idle_first", 32'(bus.first_mismatch), 32'(exp_first));
        end
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         sa, sn, idl;
        bit         req;

        tbl[0] = '{8'b10100101, 8'b10100101, -1, 0, 1'b0, 2,  1'b1, 0, 8};
        tbl[1] = '{8'b10100101, 8'b10000111, -1, 0, 1'b0, 10, 1'b0, 2, 2};
        tbl[2] = '{8'b10100101, 8'b10000111, 4,  3, 1'b0, 2,  1'b0, 2, 2};
        tbl[3] = '{8'b01101100, 8'b01101100, -1, 0, 1'b1, 0,  1'b1, 0, 8};
        tbl[4] = '{8'hFF,       8'h00,       -1, 0, 1'b0, 3,  1'b0, 8, 0};

        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'b0;
        bus.b_bit     = 1'b0;

        rst = 1'b1;
        tick();
        chk_reset("rst");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.bit_valid = 1'($urandom);
            bus.a_bit     = 1'($urandom);
            bus.b_bit     = 1'($urandom);
            tick();
            chk_reset("idle0");
        end
        bus.bit_valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].a, tbl[v].b, tbl[v].stall_after, tbl[v].stall_n, tbl[v].hold,
                      tbl[v].exp_eq, tbl[v].exp_cnt, tbl[v].exp_first);
            if (tbl[v].idle_n > 0) idle_hold(tbl[v].idle_n, tbl[v].exp_eq, tbl[v].exp_cnt, tbl[v].exp_first);
        end

        // Mid-frame reset: outputs go to reset values, no done pulse follows.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bit_valid = 1'b1;
            bus.a_bit     = 1'(i);
            bus.b_bit     = 1'b0;
            tick();
        end
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        chk_reset("midrst");
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_reset("postrst");
        end
        run_frame(8'b10100101, 8'b10100101, -1, 0, 1'b0, 1'b1, 0, 8);
        idle_hold(1, 1'b1, 0, 8);

        // Randomized frames against the counting model.
        for (int f = 0; f < 40; f++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : ra ^ 8'($urandom);
            sa  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 6));
            sn  = int'($urandom_range(1, 4));
            req = ($urandom_range(0, 3) == 0);
            idl = int'($urandom_range(0, 2));
            run_frame(ra, rb, sa, sn, req, model_cnt(ra, rb) == 0, model_cnt(ra, rb), model_first(ra, rb));
            if (idl > 0) idle_hold(idl, model_cnt(ra, rb) == 0, model_cnt(ra, rb), model_first(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
